core_muldiv_unit: RTL and testbench

- Parametrised, iterative RV32M multiply/divide unit attached to the EX stage of the five-stage core.
- Accepts one operation at a time, computes over a configurable number of cycles, then holds the result until the pipeline acknowledges it.
- `o_busy` feeds the hazard logic as an extra EX/ID/MEM stall source.
- `i_flush` lets a taken branch or jalr in EX cancel an in-flight operation.

---
 rtl/core_muldiv_unit.sv | 203 ++++++++++++++++++++
 tb/tb_core_muldiv_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_muldiv_unit.sv
`default_nettype none
// ============================================================================
// core_muldiv_unit : iterative RV32M multiply/divide unit for the EX stage
// Revision 1.0
// ============================================================================
module core_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  input  logic            i_ack,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_res,
  output logic [4:0]      o_rd
);

  localparam int c_n_iter = XLEN / BITS_PER_CYCLE;
  localparam int c_cnt_w  = (c_n_iter > 1) ? $clog2(c_n_iter) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n_iter - 1);
  localparam logic [XLEN-1:0]    c_smin = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [2:0]          r_funct3;
  logic [XLEN-1:0]     r_opb;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic                r_neg_rem;

  logic                w_s1_signed;
  logic                w_s2_signed;
  logic                w_neg1;
  logic                w_neg2;
  logic                w_is_div;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_fast;
  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;
  logic [XLEN-1:0]     w_fast_res;

  logic [XLEN:0]                  w_trial;
  logic                           w_ge;
  logic [XLEN-1:0]                w_rem;
  logic [XLEN-1:0]                w_quo;
  logic [XLEN+BITS_PER_CYCLE-1:0] w_partial;
  logic [XLEN+BITS_PER_CYCLE-1:0] w_sum;
  logic [2*XLEN-1:0]              w_acc_next;

  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_remd;
  logic [XLEN-1:0]     w_result;

  assign o_busy  = (r_state != IDLE);
  assign o_valid = (r_state == DONE);

  always_comb begin
    w_s1_signed = 1'b0;
    w_s2_signed = 1'b0;
    case (i_funct3)
      3'b001, 3'b100, 3'b110: begin
        w_s1_signed = 1'b1;
        w_s2_signed = 1'b1;
      end
      3'b010:  w_s1_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_neg1 = w_s1_signed & i_rs1[XLEN-1];
  assign w_neg2 = w_s2_signed & i_rs2[XLEN-1];
  assign w_mag1 = w_neg1 ? -i_rs1 : i_rs1;
  assign w_mag2 = w_neg2 ? -i_rs2 : i_rs2;

  // Division corner cases resolve without iterating.
  assign w_is_div   = i_funct3[2];
  assign w_div_zero = w_is_div && (i_rs2 == '0);
  assign w_div_ovf  = w_is_div && !i_funct3[0] && (i_rs1 == c_smin) && (i_rs2 == '1);
  assign w_fast     = w_div_zero || w_div_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = i_funct3[1] ? i_rs1 : '1;
    end else begin
      w_fast_res = i_funct3[1] ? '0 : i_rs1;
    end
  end

  // One iteration: r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    w_trial    = '0;
    w_ge       = 1'b0;
    w_rem      = r_acc[2*XLEN-1:XLEN];
    w_quo      = r_acc[XLEN-1:0];
    w_partial  = '0;
    w_sum      = '0;
    w_acc_next = r_acc;
    if (r_funct3[2]) begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        w_trial = {w_rem, w_quo[XLEN-1]};
        w_ge    = (w_trial >= {1'b0, r_opb});
        if (w_ge) begin
          w_trial = w_trial - {1'b0, r_opb};
        end
        w_rem = w_trial[XLEN-1:0];
        w_quo = {w_quo[XLEN-2:0], w_ge};
      end
      w_acc_next = {w_rem, w_quo};
    end else begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        if (r_acc[i]) begin
          w_partial = w_partial + ({{BITS_PER_CYCLE{1'b0}}, r_opb} << i);
        end
      end
      w_sum      = {{BITS_PER_CYCLE{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_partial;
      w_acc_next = {w_sum, r_acc[XLEN-1:BITS_PER_CYCLE]};
    end
  end

  assign w_prod = r_neg ? -w_acc_next : w_acc_next;
  assign w_quot = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
  assign w_remd = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

  always_comb begin
    w_result = '0;
    case (r_funct3)
      3'b000:                 w_result = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_result = w_quot;
      default:                w_result = w_remd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      o_res     <= '0;
      o_rd      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid && !i_flush) begin
            r_funct3  <= i_funct3;
            o_rd      <= i_rd;
            r_cnt     <= '0;
            r_neg     <= w_neg1 ^ w_neg2;
            r_neg_rem <= w_neg1;
            r_opb     <= w_is_div ? w_mag2 : w_mag1;
            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
            if (w_fast) begin
              o_res   <= w_fast_res;
              r_state <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
              o_res   <= w_result;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (i_flush || i_ack) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_core_muldiv_unit : scoreboard bench for core_muldiv_unit at 1 and 4 bits/cycle
// Revision 1.0
// ============================================================================
module tb_core_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid  [2];
  logic [2:0]  funct3 [2];
  logic [31:0] rs1    [2];
  logic [31:0] rs2    [2];
  logic [4:0]  rd     [2];
  logic        flush  [2];
  logic        ack    [2];
  logic        busy   [2];
  logic        ovalid [2];
  logic [31:0] ores   [2];
  logic [4:0]  ord    [2];

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int rd_ctr = 0;
  logic [36:0] sb_q [$];

  always #5 clk = ~clk;

  core_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid[0]), .i_funct3(funct3[0]),
    .i_rs1(rs1[0]), .i_rs2(rs2[0]), .i_rd(rd[0]), .i_flush(flush[0]), .i_ack(ack[0]),
    .o_busy(busy[0]), .o_valid(ovalid[0]), .o_res(ores[0]), .o_rd(ord[0])
  );

  core_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_valid(valid[1]), .i_funct3(funct3[1]),
    .i_rs1(rs1[1]), .i_rs2(rs2[1]), .i_rd(rd[1]), .i_flush(flush[1]), .i_ack(ack[1]),
    .o_busy(busy[1]), .o_valid(ovalid[1]), .o_res(ores[1]), .o_rd(ord[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p     = '0;
    model = '0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; model = p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); model = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); model = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; model = p[63:32]; end
      3'd4: begin
        if (b == 0)   model = 32'hFFFF_FFFF;
        else if (ovf) model = a;
        else          model = $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else        model = a / b;
      end
      3'd6: begin
        if (b == 0)   model = a;
        else if (ovf) model = 32'd0;
        else          model = $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) model = a;
        else        model = a % b;
      end
    endcase
  endfunction

  // Issue one op on unit w, check latency/result/rd, optionally stall in DONE, then ack.
  task automatic run_op(input int w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          n;
    int          exp_lat;
    logic        fast;
    logic [36:0] e;
    logic [31:0] res_seen;
    logic [4:0]  rd_seen;
    fast    = f[2] && ((b == 0) || (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    exp_lat = fast ? 0 : ((w == 0) ? 32 : 8);
    rd_ctr++;
    @(negedge clk);
    valid[w] = 1'b1; funct3[w] = f; rs1[w] = a; rs2[w] = b; rd[w] = rd_ctr[4:0];
    sb_q.push_back({rd_ctr[4:0], model(f, a, b)});
    @(posedge clk); #1;
    valid[w] = 1'b0;
    check($sformatf("busy_after_accept u%0d f%0d", w, f), busy[w], 1'b1);
    n = 0;
    while (!ovalid[w] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency u%0d f%0d", w, f), n, exp_lat);
    e = sb_q.pop_front();
    check($sformatf("res u%0d f%0d a=%0h b=%0h", w, f, a, b), ores[w], e[31:0]);
    check($sformatf("rd u%0d f%0d", w, f), ord[w], e[36:32]);
    res_seen = ores[w];
    rd_seen  = ord[w];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      valid[w] = 1'b1; funct3[w] = ~f; rs1[w] = ~a; rs2[w] = 32'd3; rd[w] = ~rd_seen;
      @(posedge clk); #1;
      check($sformatf("hold_stable u%0d c%0d", w, i), {busy[w], ovalid[w], ord[w], ores[w]},
            {1'b1, 1'b1, rd_seen, res_seen});
    end
    @(negedge clk);
    ack[w] = 1'b1;
    @(posedge clk); #1;
    ack[w]   = 1'b0;
    valid[w] = 1'b0;
    check($sformatf("idle_after_ack u%0d f%0d", w, f), {ovalid[w], busy[w]}, 2'b00);
  endtask

  initial begin
    int   seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      valid[w] = 1'b0; funct3[w] = '0; rs1[w] = '0; rs2[w] = '0;
      rd[w] = '0; flush[w] = 1'b0; ack[w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++)
      check($sformatf("reset_outputs u%0d", w), {busy[w], ovalid[w], ores[w], ord[w]}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed multiply/divide cases on both unit widths.
    for (int w = 0; w < 2; w++) begin
      run_op(w, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 0);
      run_op(w, 3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 0);
      run_op(w, 3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 0);
      run_op(w, 3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 0);
      run_op(w, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      run_op(w, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      run_op(w, 3'b101, 32'd100, 32'd7, 0);
      run_op(w, 3'b111, 32'd100, 32'd7, 0);
    end
    check("plan_mul_value", model(3'b000, 32'h7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);

    // Fast-path corners.
    run_op(0, 3'b101, 32'h1234_5678, 32'd0, 0);
    run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 3'b110, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(0, 3'b100, 32'h8000_0000, 32'h0000_0001, 0);

    // Stall in DONE with a competing request, then ack.
    run_op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5);

    // Flush at iteration 10 of a DIV.
    @(negedge clk);
    valid[0] = 1'b1; funct3[0] = 3'b100; rs1[0] = 32'd1000; rs2[0] = 32'd3; rd[0] = 5'd9;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    check("flush_clears_busy", {busy[0], ovalid[0]}, 2'b00);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ovalid[0] || busy[0]) seen = 1;
    end
    check("flush_no_result", seen, 0);
    run_op(0, 3'b100, 32'd1000, 32'd3, 0);

    // Flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    valid[0] = 1'b1; flush[0] = 1'b1; funct3[0] = 3'b000; rs1[0] = 32'd5; rs2[0] = 32'd5;
    @(posedge clk); #1;
    valid[0] = 1'b0; flush[0] = 1'b0;
    check("idle_flush_blocks_accept", busy[0], 1'b0);

    // Random operands on both units.
    for (int k = 0; k < 12; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (k % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op(k % 2, rf, ra, rb, 0);
    end

    // Asynchronous reset mid-CALC on the 4-bit unit.
    @(negedge clk);
    valid[1] = 1'b1; funct3[1] = 3'b001; rs1[1] = 32'hFFFF_0001; rs2[1] = 32'h7; rd[1] = 5'd17;
    @(posedge clk); #1;
    valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int w = 0; w < 2; w++)
      check($sformatf("async_reset u%0d", w), {busy[w], ovalid[w], ores[w], ord[w]}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ovalid[1] || busy[1]) seen = 1;
    end
    check("no_result_after_reset", seen, 0);
    run_op(1, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
